// File: rtl/dmem_responder.sv
// Fixed-latency tagged data memory behind the dcache memory bus.
// Stores and loads touch the array at acceptance; completions emerge MEM_LATENCY cycles later.
module dmem_responder #(
    parameter int MEM_LATENCY     = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int MEM_DWORDS      = 8192
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic [1:0]  proc2mem_command,
    input  logic [15:0] proc2mem_addr,
    input  logic [1:0]  proc2mem_size,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  mem2proc_tag,
    output logic [3:0]  outstanding_cnt
);
    localparam int AW = (MEM_DWORDS > 1) ? $clog2(MEM_DWORDS) : 1;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    function automatic logic [3:0] popcount15(input logic [15:1] v);
        logic [3:0] c;
        c = '0;
        for (int i = 1; i < 16; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    logic [15:1] r_busy;
    logic [3:0]  r_cnt;
    logic        r_s0_load;
    logic [63:0] r_rdata;
    logic [63:0] r_mem [MEM_DWORDS];

    logic        w_is_load;
    logic        w_is_store;
    logic        w_accept;
    logic [3:0]  w_free_tag;
    logic [3:0]  w_busy_cnt;
    logic [15:1] w_busy_next;
    logic [2:0]  w_off;
    logic [3:0]  w_nbytes;
    logic [7:0]  w_be;
    logic [63:0] w_wdata;
    logic [12:0] w_word;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_tag [MEM_LATENCY];
    logic [63:0] w_dat [MEM_LATENCY];

    assign w_is_load  = (proc2mem_command == BUS_LOAD);
    assign w_is_store = (proc2mem_command == BUS_STORE);
    assign w_busy_cnt = popcount15(r_busy);

    // Lowest-numbered free tag; 0 means every tag is busy.
    always_comb begin
        w_free_tag = '0;
        for (int i = 15; i >= 1; i--) begin
            if (!r_busy[i]) w_free_tag = 4'(i);
        end
    end

    assign w_accept = (w_is_load || w_is_store) && !stall_in && !reset
                      && (32'(w_busy_cnt) < MAX_OUTSTANDING) && (w_free_tag != 4'd0);
    assign mem2proc_response = w_accept ? w_free_tag : 4'd0;

    assign w_off    = proc2mem_addr[2:0];
    assign w_nbytes = 4'd1 << proc2mem_size;
    assign w_wdata  = proc2mem_data << {w_off, 3'b000};
    assign w_word   = proc2mem_addr[15:3];
    assign w_idx    = AW'(32'(w_word) % MEM_DWORDS);

    // Lanes past byte 7 simply fall off; nothing wraps into the next word.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_be
            assign w_be[gi] = (4'(gi) >= {1'b0, w_off}) && (4'(gi) < ({1'b0, w_off} + w_nbytes));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (w_accept && w_is_store) begin
            for (int b = 0; b < 8; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
        r_rdata <= r_mem[w_idx];
    end

    // Completion pipeline: a nonzero tag marks a valid stage.
    generate
        for (genvar gi = 0; gi < MEM_LATENCY; gi++) begin : g_stage
            logic [3:0] r_tag;
            if (gi == 0) begin : g_head
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) r_tag <= '0;
                    else       r_tag <= w_accept ? w_free_tag : 4'd0;
                end
                assign w_dat[gi] = r_s0_load ? r_rdata : 64'd0;
            end else begin : g_body
                logic [63:0] r_dat;
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        r_tag <= '0;
                        r_dat <= '0;
                    end else begin
                        r_tag <= w_tag[gi-1];
                        r_dat <= w_dat[gi-1];
                    end
                end
                assign w_dat[gi] = r_dat;
            end
            assign w_tag[gi] = r_tag;
        end
    endgenerate

    assign mem2proc_tag  = w_tag[MEM_LATENCY-1];
    assign mem2proc_data = w_dat[MEM_LATENCY-1];

    always_comb begin
        w_busy_next = '0;
        for (int i = 1; i < 16; i++) begin
            w_busy_next[i] = (r_busy[i] && (mem2proc_tag != 4'(i)))
                             || (w_accept && (w_free_tag == 4'(i)));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy    <= '0;
            r_cnt     <= '0;
            r_s0_load <= 1'b0;
        end else begin
            r_busy    <= w_busy_next;
            r_cnt     <= popcount15(w_busy_next);
            r_s0_load <= w_accept && w_is_load;
        end
    end

    assign outstanding_cnt = r_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a byte-level model.
module tb_dmem_responder;
    localparam int LAT = 4;
    localparam int MAXO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_in;
    logic [1:0]  cmd, size;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [3:0]  resp, rtag, cnt;
    logic [63:0] rdata;

    logic [1:0]  b_cmd;
    logic [15:0] b_addr;
    logic [3:0]  b_resp, b_tag, b_cnt;
    logic [63:0] b_data;

    always #5 clock = ~clock;

    dmem_responder #(.MEM_LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .MEM_DWORDS(8192)) dut (
        .clock(clock), .reset(reset), .stall_in(stall_in),
        .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_size(size),
        .proc2mem_data(wdata), .mem2proc_response(resp), .mem2proc_data(rdata),
        .mem2proc_tag(rtag), .outstanding_cnt(cnt)
    );

    dmem_responder #(.MEM_LATENCY(LAT), .MAX_OUTSTANDING(2), .MEM_DWORDS(16)) dut2 (
        .clock(clock), .reset(reset), .stall_in(1'b0),
        .proc2mem_command(b_cmd), .proc2mem_addr(b_addr), .proc2mem_size(2'd3),
        .proc2mem_data(64'd0), .mem2proc_response(b_resp), .mem2proc_data(b_data),
        .mem2proc_tag(b_tag), .outstanding_cnt(b_cnt)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit [15:1] m_busy;
    logic [3:0]  comp_tag [int];
    logic [63:0] comp_data [int];
    logic [7:0]  m_bytes [int];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [15:0] a);
        logic [63:0] v;
        int base;
        base = int'({a[15:3], 3'b000});
        v = '0;
        for (int b = 0; b < 8; b++)
            v[8*b +: 8] = m_bytes.exists(base + b) ? m_bytes[base + b] : 8'h00;
        return v;
    endfunction

    task automatic model_store(input logic [15:0] a, input logic [1:0] s, input logic [63:0] d);
        int n;
        n = 1 << s;
        for (int k = 0; k < n; k++)
            if (int'(a[2:0]) + k < 8) m_bytes[int'(a) + k] = d[8*k +: 8];
    endtask

    function automatic logic [3:0] model_grant(input logic [1:0] c, input logic st);
        if ((c == 2'd1 || c == 2'd2) && !st && $countones(m_busy) < MAXO)
            for (int t = 1; t < 16; t++) if (!m_busy[t]) return 4'(t);
        return 4'd0;
    endfunction

    // One bus cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic [1:0] c, input logic [15:0] a, input logic [1:0] s,
                        input logic [63:0] d, input logic st);
        logic [3:0] g;
        cmd = c; addr = a; size = s; wdata = d; stall_in = st;
        @(negedge clock);
        g = model_grant(c, st);
        chk("resp", {60'd0, resp}, {60'd0, g});
        chk("tag", {60'd0, rtag}, comp_tag.exists(cyc) ? {60'd0, comp_tag[cyc]} : 64'd0);
        chk("data", rdata, comp_data.exists(cyc) ? comp_data[cyc] : 64'd0);
        chk("cnt", {60'd0, cnt}, 64'($countones(m_busy)));
        if (g != 0) $display("txn cyc=%0d cmd=%0d addr=%h size=%0d tag=%0d", cyc, c, a, s, g);
        @(posedge clock);
        if (comp_tag.exists(cyc)) m_busy[comp_tag[cyc]] = 1'b0;
        if (g != 0) begin
            m_busy[g] = 1'b1;
            comp_tag[cyc + LAT]  = g;
            comp_data[cyc + LAT] = (c == 2'd1) ? model_load(a) : 64'd0;
            if (c == 2'd2) model_store(a, s, d);
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'd0, 16'd0, 2'd0, 64'd0, 1'b0);
    endtask

    function automatic logic [63:0] init_val(input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0101_0101);
    endfunction

    logic [3:0] exp2 [6];

    initial begin
        reset = 1'b1; stall_in = 1'b0; cmd = '0; addr = '0; size = '0; wdata = '0;
        b_cmd = '0; b_addr = '0;
        m_busy = '0;
        exp2 = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1};
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_tag", {60'd0, rtag}, 64'd0);
        chk("reset_cnt", {60'd0, cnt}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Outstanding limit of 2 on the second instance.
        for (int k = 0; k < 6; k++) begin
            b_cmd = 2'd1; b_addr = 16'(8 * k);
            @(negedge clock);
            chk("lim_resp", {60'd0, b_resp}, {60'd0, exp2[k]});
            if (k == 0) chk("lim_idle_data", b_data, 64'd0);
            if (k == 2) chk("lim_cnt", {60'd0, b_cnt}, 64'd2);
            if (k == 4) chk("lim_tag", {60'd0, b_tag}, 64'd1);
            @(posedge clock); #1;
        end
        b_cmd = 2'd0;

        // Known contents for bytes 0x00..0xFF.
        for (int i = 0; i < 32; i++) step(2'd2, 16'(8 * i), 2'd3, init_val(i), 1'b0);
        idle(LAT + 2);

        // Store then load to the same word.
        step(2'd2, 16'h0040, 2'd3, 64'h1122334455667788, 1'b0);
        step(2'd1, 16'h0040, 2'd0, 64'd0, 1'b0);
        idle(2);
        chk("st_done_tag", {60'd0, rtag}, 64'd1);
        chk("st_done_data", rdata, 64'd0);
        idle(1);
        chk("ld_done_tag", {60'd0, rtag}, 64'd2);
        chk("ld_done_data", rdata, 64'h1122334455667788);
        idle(LAT);

        // Byte store into the middle of the word.
        step(2'd2, 16'h0043, 2'd0, 64'h00000000000000AB, 1'b0);
        step(2'd1, 16'h0040, 2'd0, 64'd0, 1'b0);
        idle(3);
        chk("subword_data", rdata, 64'h11223344AB667788);
        idle(LAT);

        // Stalled store leaves memory alone.
        step(2'd2, 16'h0080, 2'd3, 64'hDEADBEEFDEADBEEF, 1'b1);
        step(2'd1, 16'h0080, 2'd0, 64'd0, 1'b0);
        idle(3);
        chk("stall_data", rdata, init_val(16));
        idle(LAT);

        // Doubleword at offset 7 only reaches the top byte.
        step(2'd2, 16'h0047, 2'd3, 64'h77665544332211EE, 1'b0);
        step(2'd1, 16'h0040, 2'd0, 64'd0, 1'b0);
        idle(3);
        chk("lanedrop_data", rdata, 64'hEE223344AB667788);
        idle(LAT);

        // Back-to-back loads.
        for (int k = 0; k < 4; k++) step(2'd1, 16'(8 * k), 2'd3, 64'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_tag", {60'd0, rtag}, 64'(k + 1));
            chk("b2b_data", rdata, init_val(k));
            idle(1);
        end
        idle(LAT);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(2'($urandom_range(0, 3)), 16'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
        idle(LAT + 2);

        // Asynchronous reset with loads in flight.
        step(2'd1, 16'h0040, 2'd0, 64'd0, 1'b0);
        step(2'd1, 16'h0048, 2'd0, 64'd0, 1'b0);
        step(2'd1, 16'h0050, 2'd0, 64'd0, 1'b0);
        cmd = 2'd1;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tag", {60'd0, rtag}, 64'd0);
        chk("arst_data", rdata, 64'd0);
        chk("arst_cnt", {60'd0, cnt}, 64'd0);
        chk("arst_resp", {60'd0, resp}, 64'd0);
        cmd = 2'd0;
        m_busy = '0;
        comp_tag.delete();
        comp_data.delete();
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        idle(20);
        step(2'd1, 16'h0058, 2'd0, 64'd0, 1'b0);
        idle(LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
